// File: rtl/llc_bus_ctrl.sv
// llc_bus_ctrl: queues cache requests, broadcasts them on the snoop bus and merges snooper results.
module llc_bus_ctrl #(
  parameter int          ADDR_W      = 32,
  parameter int          NUM_SNP     = 4,
  parameter int          FIFO_DEPTH  = 4,
  parameter int          CNT_W       = 32,
  parameter int          SNP_TIMEOUT = 8,
  parameter logic [3:0]  CACHE_ID    = 4'd0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_op,
  input  logic [ADDR_W-1:0]      req_addr,
  output logic                   bus_valid,
  output logic [2:0]             bus_op,
  output logic [ADDR_W-1:0]      bus_addr,
  output logic [3:0]             bus_id,
  input  logic [NUM_SNP-1:0]     snp_valid,
  input  logic [2*NUM_SNP-1:0]   snp_result,
  output logic                   rsp_valid,
  output logic [1:0]             rsp_result,
  output logic                   rsp_timeout,
  output logic [CNT_W-1:0]       read_cnt,
  output logic [CNT_W-1:0]       write_cnt,
  output logic [CNT_W-1:0]       hitm_cnt,
  output logic                   busy
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(SNP_TIMEOUT + 1);
  localparam logic [2:0] OP_READ = 3'd1, OP_WRITE = 3'd2, OP_INV = 3'd3, OP_RWIM = 3'd4;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESPOND} state_t;
  state_t state_q, state_d;
  logic [2:0]          op_mem_q   [FIFO_DEPTH];
  logic [ADDR_W-1:0]   addr_mem_q [FIFO_DEPTH];
  logic [AW-1:0]       wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]         cnt_q, cnt_d;
  logic                pend_q, pend_d;
  logic [NUM_SNP-1:0]  lv_q, lv_d;
  logic [2*NUM_SNP-1:0] lr_q, lr_d;
  logic [TW-1:0]       wcnt_q, wcnt_d;
  logic                to_q, to_d;
  logic [CNT_W-1:0]    rd_q, rd_d, wr_q, wr_d, hm_q, hm_d;
  logic                legal, push, pop, all_done, any_hit, any_hitm;
  logic [2:0]          head_op;
  logic [1:0]          comb_res;
  assign req_ready = cnt_q != (AW+1)'(FIFO_DEPTH);
  assign legal     = req_op inside {OP_READ, OP_WRITE, OP_INV, OP_RWIM};
  assign push      = req_valid && req_ready && legal;
  assign pop       = state_q == RESPOND;
  assign head_op   = op_mem_q[rp_q];
  assign all_done  = &lv_d;
  assign comb_res  = any_hitm ? 2'd2 : any_hit ? 2'd1 : 2'd0;
  assign bus_valid   = state_q == ISSUE;
  assign bus_op      = bus_valid ? head_op : '0;
  assign bus_addr    = bus_valid ? addr_mem_q[rp_q] : '0;
  assign bus_id      = bus_valid ? CACHE_ID : '0;
  assign rsp_valid   = pop;
  assign rsp_result  = pop ? comb_res : '0;
  assign rsp_timeout = pop && to_q;
  assign read_cnt    = rd_q;
  assign write_cnt   = wr_q;
  assign hitm_cnt    = hm_q;
  assign busy        = state_q != IDLE || cnt_q != '0;
  // First strobe per snooper wins; latches only open while waiting.
  always_comb begin
    lv_d     = lv_q;
    lr_d     = lr_q;
    any_hit  = 1'b0;
    any_hitm = 1'b0;
    for (int i = 0; i < NUM_SNP; i++) begin
      if (state_q == WAIT && snp_valid[i] && !lv_q[i]) begin
        lv_d[i]       = 1'b1;
        lr_d[2*i +: 2] = snp_result[2*i +: 2];
      end
      any_hit  = any_hit  || lr_q[2*i +: 2] == 2'd1;
      any_hitm = any_hitm || lr_q[2*i +: 2] == 2'd2;
    end
    if (pop) begin
      lv_d = '0;
      lr_d = '0;
    end
  end
  always_comb begin
    state_d = state_q;
    wcnt_d  = '0;
    to_d    = to_q;
    case (state_q)
      IDLE:    state_d = (pend_q && cnt_q != '0) ? ISSUE : IDLE;
      ISSUE: begin
        state_d = head_op == OP_WRITE ? RESPOND : WAIT;
        to_d    = 1'b0;
      end
      WAIT: begin
        wcnt_d = wcnt_q + TW'(1);
        if (all_done) state_d = RESPOND;
        else if (wcnt_q == TW'(SNP_TIMEOUT - 1)) begin
          state_d = RESPOND;
          to_d    = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        to_d    = 1'b0;
      end
    endcase
  end
  // A freshly queued request sits one cycle before issue (pend_q lags the occupancy).
  always_comb begin
    wp_d   = push ? wp_q + AW'(1) : wp_q;
    rp_d   = pop ? rp_q + AW'(1) : rp_q;
    cnt_d  = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    pend_d = cnt_q != '0;
    rd_d   = (pop && (head_op == OP_READ || head_op == OP_RWIM) && rd_q != '1) ? rd_q + CNT_W'(1) : rd_q;
    wr_d   = (pop && head_op == OP_WRITE && wr_q != '1) ? wr_q + CNT_W'(1) : wr_q;
    hm_d   = (pop && comb_res == 2'd2 && hm_q != '1) ? hm_q + CNT_W'(1) : hm_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      pend_q  <= 1'b0;
      lv_q    <= '0;
      lr_q    <= '0;
      wcnt_q  <= '0;
      to_q    <= 1'b0;
      rd_q    <= '0;
      wr_q    <= '0;
      hm_q    <= '0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      lv_q    <= lv_d;
      lr_q    <= lr_d;
      wcnt_q  <= wcnt_d;
      to_q    <= to_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      hm_q    <= hm_d;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        op_mem_q[i]   <= '0;
        addr_mem_q[i] <= '0;
      end
    end else if (push) begin
      op_mem_q[wp_q]   <= req_op;
      addr_mem_q[wp_q] <= req_addr;
    end
  end
endmodule

// File: tb/tb_llc_bus_ctrl.sv
// tb_llc_bus_ctrl: directed scoreboard bench for llc_bus_ctrl, with a CNT_W=2 twin for saturation.
module tb_llc_bus_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic        req_valid = 1'b0;
  logic [2:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [3:0]  snp_valid = '0;
  logic [7:0]  snp_result = '0;
  logic        req_ready, bus_valid, rsp_valid, rsp_timeout, busy;
  logic [2:0]  bus_op;
  logic [31:0] bus_addr, read_cnt, write_cnt, hitm_cnt;
  logic [3:0]  bus_id;
  logic [1:0]  rsp_result;
  logic        s_req_ready, s_bus_valid, s_rsp_valid, s_rsp_timeout, s_busy;
  logic [2:0]  s_bus_op;
  logic [31:0] s_bus_addr;
  logic [3:0]  s_bus_id;
  logic [1:0]  s_rsp_result, s_read_cnt, s_write_cnt, s_hitm_cnt;
  llc_bus_ctrl #(.CACHE_ID(4'd5)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op),
    .req_addr(req_addr), .bus_valid(bus_valid), .bus_op(bus_op), .bus_addr(bus_addr),
    .bus_id(bus_id), .snp_valid(snp_valid), .snp_result(snp_result), .rsp_valid(rsp_valid),
    .rsp_result(rsp_result), .rsp_timeout(rsp_timeout), .read_cnt(read_cnt),
    .write_cnt(write_cnt), .hitm_cnt(hitm_cnt), .busy(busy));
  llc_bus_ctrl #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(s_req_ready), .req_op(req_op),
    .req_addr(req_addr), .bus_valid(s_bus_valid), .bus_op(s_bus_op), .bus_addr(s_bus_addr),
    .bus_id(s_bus_id), .snp_valid(snp_valid), .snp_result(snp_result), .rsp_valid(s_rsp_valid),
    .rsp_result(s_rsp_result), .rsp_timeout(s_rsp_timeout), .read_cnt(s_read_cnt),
    .write_cnt(s_write_cnt), .hitm_cnt(s_hitm_cnt), .busy(s_busy));
  typedef struct packed {logic [2:0] op; logic [31:0] addr;} bus_t;
  typedef struct packed {logic [1:0] res; logic to;} rsp_t;
  bus_t bus_q[$];
  rsp_t rsp_q[$];
  bus_t be;
  rsp_t re;
  int checks = 0, errors = 0;
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  always @(negedge clk) begin
    if (!rst) begin
      if (bus_valid) begin
        if (bus_q.size() == 0) chk("bus_unexpected", 64'd1, 64'd0);
        else begin
          be = bus_q.pop_front();
          chk("bus_op", 64'(bus_op), 64'(be.op));
          chk("bus_addr", 64'(bus_addr), 64'(be.addr));
        end
      end else chk("bus_idle_zero", 64'({bus_op, bus_addr, bus_id}), 64'd0);
      if (rsp_valid) begin
        if (rsp_q.size() == 0) chk("rsp_unexpected", 64'd1, 64'd0);
        else begin
          re = rsp_q.pop_front();
          chk("rsp_result", 64'(rsp_result), 64'(re.res));
          chk("rsp_timeout", 64'(rsp_timeout), 64'(re.to));
        end
      end else chk("rsp_idle_zero", 64'({rsp_result, rsp_timeout}), 64'd0);
    end
  end
  task automatic do_reset();
    rst = 1'b1;
    req_valid = 1'b0;
    snp_valid = '0;
    bus_q.delete();
    rsp_q.delete();
    tick();
    tick();
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_outs", 64'({busy, bus_valid, rsp_valid}), 64'd0);
    chk("rst_cnts", 64'(read_cnt | write_cnt | hitm_cnt), 64'd0);
    rst = 1'b0;
  endtask
  task automatic send(input logic [2:0] op, input logic [31:0] addr, input logic [1:0] res, input logic to);
    int n = 0;
    req_valid = 1'b1;
    req_op = op;
    req_addr = addr;
    while (!req_ready && n < 50) begin
      tick();
      n++;
    end
    if (n == 50) chk("send_ready_bound", 64'd0, 64'd1);
    bus_q.push_back('{op, addr});
    rsp_q.push_back('{res, to});
    tick();
    req_valid = 1'b0;
  endtask
  task automatic wait_bus();
    int n = 0;
    while (!bus_valid && n < 50) begin
      tick();
      n++;
    end
    chk("bus_seen", 64'(bus_valid), 64'd1);
  endtask
  task automatic wait_drain();
    int n = 0;
    while (rsp_q.size() != 0 && n < 200) begin
      tick();
      n++;
    end
    chk("drain", 64'(rsp_q.size()), 64'd0);
  endtask
  task automatic snoop(input logic [3:0] v0, input logic [7:0] r0, input logic [3:0] v1, input logic [7:0] r1);
    wait_bus();
    tick();
    snp_valid = v0;
    snp_result = r0;
    tick();
    snp_valid = v1;
    snp_result = r1;
    tick();
    snp_valid = '0;
    snp_result = '0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int n;
    do_reset();
    // READ 0x1000 timing: bus on cycle 2, response on cycle 4
    req_valid = 1'b1;
    req_op = 3'd1;
    req_addr = 32'h1000;
    bus_q.push_back('{3'd1, 32'h1000});
    rsp_q.push_back('{2'd0, 1'b0});
    chk("p1_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("p1_bus_c0", 64'(bus_valid), 64'd0);
    tick();
    chk("p1_bus_c1", 64'(bus_valid), 64'd0);
    tick();
    chk("p1_bus_c2", 64'(bus_valid), 64'd1);
    chk("p1_bus_id", 64'(bus_id), 64'd5);
    tick();
    snp_valid = 4'hf;
    snp_result = 8'h00;
    chk("p1_rsp_c3", 64'(rsp_valid), 64'd0);
    tick();
    snp_valid = '0;
    chk("p1_rsp_c4", 64'(rsp_valid), 64'd1);
    tick();
    chk("p1_read_cnt", 64'(read_cnt), 64'd1);
    chk("p1_busy", 64'(busy), 64'd0);
    // RWIM: HIT,HITM then a repeat strobe from snooper 1 that must be ignored
    do_reset();
    send(3'd4, 32'h2000, 2'd2, 1'b0);
    snoop(4'b0011, 8'b0000_1001, 4'b1110, 8'b0100_0000);
    wait_drain();
    chk("p2_read_cnt", 64'(read_cnt), 64'd1);
    chk("p2_hitm_cnt", 64'(hitm_cnt), 64'd1);
    chk("p2_write_cnt", 64'(write_cnt), 64'd0);
    // timeout with snooper 3 silent; its HITM during ISSUE must be ignored
    do_reset();
    send(3'd1, 32'h3000, 2'd0, 1'b1);
    wait_bus();
    snp_valid = 4'b1000;
    snp_result = 8'b1000_0000;
    tick();
    snp_valid = 4'b0111;
    snp_result = 8'h00;
    n = 0;
    while (!rsp_valid && n < 20) begin
      tick();
      n++;
      snp_valid = '0;
    end
    chk("p3_timeout_latency", 64'(n), 64'd8);
    wait_drain();
    chk("p3_hitm_cnt", 64'(hitm_cnt), 64'd0);
    // five back-to-back writes against a depth-4 queue
    do_reset();
    req_valid = 1'b1;
    req_op = 3'd2;
    for (int i = 0; i < 4; i++) begin
      req_addr = 32'h4000 + 32'(i);
      bus_q.push_back('{3'd2, req_addr});
      rsp_q.push_back('{2'd0, 1'b0});
      chk("p4_ready", 64'(req_ready), 64'd1);
      tick();
    end
    chk("p4_full", 64'(req_ready), 64'd0);
    req_addr = 32'h4004;
    bus_q.push_back('{3'd2, req_addr});
    rsp_q.push_back('{2'd0, 1'b0});
    n = 0;
    while (!req_ready && n < 20) begin
      tick();
      n++;
    end
    tick();
    req_valid = 1'b0;
    wait_drain();
    chk("p4_write_cnt", 64'(write_cnt), 64'd5);
    chk("p4_read_cnt", 64'(read_cnt), 64'd0);
    // saturation with encoding-3 results (treated as NOHIT), then an illegal op
    do_reset();
    for (int i = 0; i < 5; i++) begin
      send(3'd1, 32'h5000 + 32'(i * 4), 2'd0, 1'b0);
      snoop(4'hf, 8'hff, 4'h0, 8'h00);
      wait_drain();
    end
    chk("p5_read_cnt", 64'(read_cnt), 64'd5);
    chk("p5_sat_read_cnt", 64'(s_read_cnt), 64'd3);
    chk("p5_hitm_cnt", 64'(hitm_cnt), 64'd0);
    req_valid = 1'b1;
    req_op = 3'd7;
    req_addr = 32'h7777;
    chk("p5_ill_ready", 64'(req_ready), 64'd1);
    tick();
    req_valid = 1'b0;
    chk("p5_ill_busy", 64'(busy), 64'd0);
    repeat (6) tick();
    chk("p5_ill_idle", 64'(busy), 64'd0);
    // reset while waiting with two more queued
    do_reset();
    send(3'd1, 32'h6000, 2'd0, 1'b0);
    send(3'd1, 32'h6004, 2'd0, 1'b0);
    send(3'd1, 32'h6008, 2'd0, 1'b0);
    tick();
    chk("p6_busy_pre", 64'(busy), 64'd1);
    chk("p6_full_pre", 64'(req_ready), 64'd1);
    #2;
    rst = 1'b1;
    bus_q.delete();
    rsp_q.delete();
    #1;
    chk("p6_busy", 64'(busy), 64'd0);
    chk("p6_ready", 64'(req_ready), 64'd1);
    chk("p6_strobes", 64'({bus_valid, rsp_valid}), 64'd0);
    tick();
    rst = 1'b0;
    repeat (15) tick();
    chk("p6_read_cnt", 64'(read_cnt), 64'd0);
    chk("p6_idle", 64'(busy), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/llc_bus_ctrl.md
LLC_BUS_CTRL -- requirements
Module: llc_bus_ctrl

Interface
REQ-001 Parameter ADDR_W, default 32, width of bus address.
REQ-002 Parameter NUM_SNP, default 4, number of snooping caches (1..15).
REQ-003 Parameter FIFO_DEPTH, default 4, request queue depth (power of 2, >=2).
REQ-004 Parameter CNT_W, default 32, statistics counter width.
REQ-005 Parameter SNP_TIMEOUT, default 8, maximum WAIT cycles (>=1).
REQ-006 Parameter CACHE_ID, default 0, 4-bit ID driven on bus_id.
REQ-007 One clock; reset is asynchronous and active-high.
REQ-008 clk  in  1  clock, rising edge.
REQ-009 rst  in  1  asynchronous active-high reset.
REQ-010 req_valid/req_ready  in/out  1/1  request handshake; transfer when both high at clk edge.
REQ-011 req_op  in  3  READ=1, WRITE=2, INVALIDATE=3, RWIM=4.
REQ-012 req_addr  in  ADDR_W  request address.
REQ-013 bus_valid  out  1  one-cycle bus broadcast strobe.
REQ-014 bus_op/bus_addr/bus_id  out  3/ADDR_W/4  broadcast op, address, CACHE_ID.
REQ-015 snp_valid  in  NUM_SNP  per-snooper result strobe.
REQ-016 snp_result  in  2*NUM_SNP  per-snooper result, snooper i at bits [2i+1:2i]; NOHIT=0, HIT=1, HITM=2.
REQ-017 rsp_valid  out  1  one-cycle completion strobe.
REQ-018 rsp_result/rsp_timeout  out  2/1  combined snoop result; timeout flag.
REQ-019 read_cnt/write_cnt/hitm_cnt  out  CNT_W each  statistics.
REQ-020 busy  out  1  high when FSM not IDLE or FIFO non-empty.

Function
REQ-021 req_ready SHALL equal (FIFO not full); requests with illegal op (0,5,6,7) SHALL be accepted and discarded, never enqueued.
REQ-022 FIFO SHALL be first-in-first-out; push and pop in the same cycle SHALL both take effect; pointers wrap modulo FIFO_DEPTH.
REQ-023 FSM states IDLE, ISSUE, WAIT, RESPOND; IDLE->ISSUE when FIFO non-empty, else stay.
REQ-024 ISSUE SHALL last one cycle with bus_valid=1 and bus_op/bus_addr from FIFO head; next state WAIT for READ/RWIM/INVALIDATE, RESPOND for WRITE.
REQ-025 bus_valid SHALL first assert 2 cycles after the handshake edge of a request entering an empty FIFO with FSM in IDLE.
REQ-026 In WAIT, snp_valid[i]=1 SHALL latch snooper i's result once (first strobe wins); strobes outside WAIT SHALL be ignored.
REQ-027 Combined result: HITM if any latched HITM, else HIT if any latched HIT, else NOHIT; encoding 3 SHALL be treated as NOHIT.
REQ-028 WAIT->RESPOND when all NUM_SNP results latched (including strobes in the current cycle), rsp_timeout=0.
REQ-029 WAIT cycle counter starts at 0; if not all latched when it equals SNP_TIMEOUT-1, WAIT->RESPOND with rsp_timeout=1 and result from latched subset.
REQ-030 RESPOND SHALL last one cycle: rsp_valid=1, FIFO pop, counters update, latches cleared, ->IDLE; WRITE responds NOHIT, rsp_timeout=0.
REQ-031 read_cnt SHALL increment for READ and RWIM, write_cnt for WRITE, hitm_cnt when rsp_result=HITM; INVALIDATE increments only hitm_cnt if applicable.
REQ-032 Counters SHALL saturate at 2^CNT_W-1.
REQ-033 bus_op/bus_addr/rsp_result/rsp_timeout SHALL be 0 when their strobe is low.

Reset
REQ-034 rst=1 SHALL immediately set FSM IDLE, FIFO empty, latches and WAIT counter 0, all outputs 0 except req_ready=1.
REQ-035 Reset mid-transaction SHALL abandon the in-flight and queued requests with no rsp_valid.
REQ-036 First request SHALL be accepted on the first rising edge after rst deasserts.

Verification
REQ-037 READ 0x1000, all 4 snoopers NOHIT on 1st WAIT cycle -> bus_valid cycle 2, rsp_valid cycle 4, result 0, read_cnt=1.
REQ-038 RWIM 0x2000, snoopers return HIT,HITM,NOHIT,HIT -> rsp_result=2, read_cnt=1, hitm_cnt=1.
REQ-039 READ with snooper 3 silent, SNP_TIMEOUT=8 -> rsp_valid 8 cycles after WAIT entry, rsp_timeout=1.
REQ-040 Push 5 WRITEs back-to-back, FIFO_DEPTH=4 -> req_ready low when 4 queued, 5 rsp_valid in order, write_cnt=5.
REQ-041 Assert rst during WAIT with 2 queued -> no rsp_valid, busy=0, req_ready=1 immediately.
REQ-042 CNT_W=2, 5 READs -> read_cnt saturates at 3; illegal op 7 -> no bus_valid.
